if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage of the OpenMIPS pipeline, sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues sequential word fetches to instruction memory over a req/ack handshake. It buffers returned instructions in a small FIFO and presents them to IF/ID as a valid/ready stream. Branch redirects from decode flush the buffer, and any in-flight memory response is discarded.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- DEPTH, 2, fetch-buffer entries; power of two, ≥2.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- branch_flag_i  in  1  redirect pulse from ID; one cycle per redirect.
- branch_target_i  in  32  redirect address; bits [1:0] ignored, treated as 0.
- rom_req  out  1  instruction-memory request, registered.
- rom_addr  out  32  request address, registered, word-aligned.
- rom_ack  in  1  one-cycle response strobe; valid only while rom_req=1.
- rom_data  in  32  instruction word, valid with rom_ack.
- id_ready  in  1  IF/ID accepts the head entry this cycle.
- if_valid  out  1  head entry available.
- if_pc  out  32  PC of head entry; ZeroWord when if_valid=0.
- if_inst  out  32  instruction of head entry; ZeroWord (NOP) when if_valid=0.

## Operation
- State: fetch_pc (next sequential address), circular buffer of DEPTH {pc, inst} entries with head/tail pointers and count (0..DEPTH), FSM {IDLE, BUSY, DROP}.
- Outputs:
  - if_valid = (count≠0) & ~branch_flag_i.
  - if_pc/if_inst are the head entry's pc/inst when if_valid=1, else ZeroWord.
- Pop: if_valid & id_ready, head advances.
- Push: on ack accepted in BUSY.
- Push and pop may occur in the same cycle.
- room = (count − pop + push) < DEPTH, evaluated at the end of the cycle.
- Request rule: once rom_req=1, rom_req and rom_addr hold until the cycle rom_ack=1. At most one request is outstanding.
- IDLE (rom_req=0):
  - room → rom_req←1, rom_addr←fetch_pc, go to BUSY.
- BUSY (rom_req=1):
  - ack, no redirect → push {rom_addr, rom_data}, fetch_pc←rom_addr+4.
    - If room after push: rom_addr←rom_addr+4, stay BUSY.
    - Else: rom_req←0, go to IDLE.
  - redirect, no ack → go to DROP, fetch_pc←target; rom_req/rom_addr unchanged.
  - redirect with ack → data discarded, rom_addr←target, fetch_pc←target+4 on its later ack; stay BUSY.
- DROP (rom_req=1):
  - ack → data discarded, rom_addr←fetch_pc, stay rom_req=1, go to BUSY.
  - Further redirects update fetch_pc; the latest target wins.
- Redirect (any state):
  - count←0, pointers reset; a same-cycle pop is void.
  - From IDLE: rom_req←1, rom_addr←target, go to BUSY.
- Address arithmetic is 32-bit, modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Full (count=DEPTH) with no pop: no new request is issued.
- Empty: if_valid=0 and the outputs read ZeroWord.

## Timing
- Reset (asynchronous, immediate):
  - rom_req=0, rom_addr=RESET_PC, fetch_pc=RESET_PC, state IDLE, count=0.
  - if_valid=0, if_pc=if_inst=ZeroWord.
- First rising edge after rst deasserts: rom_req=1, rom_addr=RESET_PC.
- ack → if_valid: 1 cycle; the entry is visible the cycle after ack.
- Zero-wait memory (ack in every cycle rom_req=1) with id_ready=1: one instruction per cycle sustained, with rom_addr stepping by 4 each cycle.
- Redirect → first target instruction at if_valid:
  - 2 cycles if no request was pending, or if ack coincided with the redirect.
  - Otherwise 2 cycles after the dropped request's ack.
- rst asserted mid-request: the outstanding request is abandoned. rom_req drops immediately and any subsequent ack is ignored.

## Test plan
- Reset release with zero-wait ack, id_ready=1:
  - rom_addr sequence 0,4,8,…
  - if_valid high from cycle 2.
  - if_pc follows rom_addr one cycle later; if_inst equals the returned data.
- id_ready=0 with DEPTH=2:
  - Exactly 2 entries are pushed (PC 0,4), then rom_req falls.
  - Raising id_ready pops PC 0 then 4 while fetching resumes at 8.
- Memory ack delayed 3 cycles:
  - rom_req and rom_addr are stable throughout the wait.
  - Exactly one entry is pushed per ack.
- Redirect to 0x100 while a request for 0x8 is outstanding:
  - The 0x8 data is dropped.
  - The next request is 0x100; if_valid is 0 until PC 0x100 appears.
- Redirect coinciding with ack, and redirect while full with a same-cycle pop:
  - Buffer empties with no spurious entry.
  - Next rom_addr equals the target with bits [1:0] cleared.
- rst pulse mid-BUSY, plus a wrap check:
  - Reset: outputs return to reset values immediately, and fetch restarts at RESET_PC.
  - Wrap: with RESET_PC=32'hFFFF_FFF8, rom_addr sequence is …FFF8, …FFFC, 0.

Source files
------------

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - fetch-stage bus bundle: redirect, instruction-memory req/ack and IF/ID stream
//
// Signals:
//   branch_flag_i, branch_target_i : redirect pulse and target from ID
//   rom_req, rom_addr              : instruction-memory request (held until ack)
//   rom_ack, rom_data              : one-cycle response strobe and instruction word
//   id_ready                       : IF/ID accepts the head entry
//   if_valid, if_pc, if_inst       : head entry presented to IF/ID
// master = fetch stage, slave = memory / decode side.
interface if_fetch_if;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_data;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    modport master (
        input  branch_flag_i, branch_target_i, rom_ack, rom_data, id_ready,
        output rom_req, rom_addr, if_valid, if_pc, if_inst
    );

    modport slave (
        output branch_flag_i, branch_target_i, rom_ack, rom_data, id_ready,
        input  rom_req, rom_addr, if_valid, if_pc, if_inst
    );
endinterface

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - OpenMIPS instruction-fetch stage with fetch buffer and redirect handling
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : if_fetch_if.master (redirect in, memory req/ack, IF/ID valid/ready stream)
// Parameters:
//   RESET_PC : first PC fetched after reset
//   DEPTH    : fetch-buffer entries (power of two, >= 2)
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    if_fetch_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   buf_pc   [DEPTH];
    logic [31:0]   buf_inst [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [31:0]   target;
    logic          ack;
    logic          push;
    logic          pop;
    logic          room;

    assign target = bus.branch_target_i & 32'hFFFF_FFFC;
    assign ack    = bus.rom_req & bus.rom_ack;

    // A redirect hides the head entry so decode never consumes a stale
    // instruction in the same cycle the buffer is being flushed.
    assign bus.if_valid = (count != '0) & ~bus.branch_flag_i;
    assign pop          = bus.if_valid & bus.id_ready;
    assign push         = (state == S_BUSY) & ack & ~bus.branch_flag_i;

    // Occupancy at the end of this cycle; decides whether another request fits.
    assign count_next = count - CW'(pop) + CW'(push);
    assign room       = count_next < CW'(DEPTH);

    assign bus.if_pc   = bus.if_valid ? buf_pc[head]   : ZERO_WORD;
    assign bus.if_inst = bus.if_valid ? buf_inst[head] : ZERO_WORD;

    // Buffer storage needs no reset: entries are only read while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[tail]   <= bus.rom_addr;
            buf_inst[tail] <= bus.rom_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            fetch_pc     <= RESET_PC;
            bus.rom_req  <= 1'b0;
            bus.rom_addr <= RESET_PC;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
        end else begin
            if (bus.branch_flag_i) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PW'(1);
                if (pop)  head <= head + PW'(1);
                count <= count_next;
            end

            case (state)
                S_IDLE: begin
                    if (bus.branch_flag_i) begin
                        bus.rom_req  <= 1'b1;
                        bus.rom_addr <= target;
                        fetch_pc     <= target;
                        state        <= S_BUSY;
                    end else if (room) begin
                        bus.rom_req  <= 1'b1;
                        bus.rom_addr <= fetch_pc;
                        state        <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (ack) begin
                        if (bus.branch_flag_i) begin
                            // Response belongs to the old path: drop it and
                            // reissue straight at the target.
                            bus.rom_addr <= target;
                            fetch_pc     <= target;
                        end else begin
                            fetch_pc <= bus.rom_addr + 32'd4;
                            if (room) begin
                                bus.rom_addr <= bus.rom_addr + 32'd4;
                            end else begin
                                bus.rom_req <= 1'b0;
                                state       <= S_IDLE;
                            end
                        end
                    end else if (bus.branch_flag_i) begin
                        // Request must stay up until memory answers; remember
                        // where to go once the stale response arrives.
                        fetch_pc <= target;
                        state    <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (ack) begin
                        bus.rom_addr <= bus.branch_flag_i ? target : fetch_pc;
                        if (bus.branch_flag_i) fetch_pc <= target;
                        state <= S_BUSY;
                    end else if (bus.branch_flag_i) begin
                        fetch_pc <= target;
                    end
                end
                default: begin
                    bus.rom_req <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end
endmodule
